// File: rtl/board_scanner_pkg.sv
// Shared types and constants for the board_scanner shift-register chain reader.
package board_scanner_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    COMMIT
  } scan_state_t;

  localparam int SCAN_COUNT_W = 16;

  // Counter width that can hold values 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/board_scanner_if.sv
// Sensor-chain pins plus the debounced-word interface to the I/O manager.
interface board_scanner_if #(parameter int NUM_BITS = 32);
  import board_scanner_pkg::*;

  logic                    scan_en;
  logic                    in_val;
  logic                    sr_clk;
  logic                    parallel_mode;
  logic [NUM_BITS-1:0]     sensor_data;
  logic                    data_valid;
  logic                    changed;
  logic [NUM_BITS-1:0]     change_mask;
  logic                    change_ack;
  logic [SCAN_COUNT_W-1:0] scan_count;

  modport slave (
    input  scan_en, in_val, change_ack,
    output sr_clk, parallel_mode, sensor_data, data_valid, changed, change_mask, scan_count
  );

  modport master (
    output scan_en, in_val, change_ack,
    input  sr_clk, parallel_mode, sensor_data, data_valid, changed, change_mask, scan_count
  );

endinterface

// File: rtl/board_scanner_tick.sv
// CLK_DIV down-counter: o_tc is high on the last cycle of a timed phase.
// i_restart reloads the count so the next phase lasts exactly CLK_DIV cycles.
module scanner_tick
  import board_scanner_pkg::*;
#(
  parameter int CLK_DIV = 50
) (
  input  logic clock,
  input  logic reset,
  input  logic i_restart,
  output logic o_tc
);

  localparam int            CW       = cnt_w(CLK_DIV);
  localparam logic [CW-1:0] LOAD_VAL = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= LOAD_VAL;
    end else if (i_restart) begin
      r_cnt <= LOAD_VAL;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/board_scanner.sv
// Scans a PISO chain into a NUM_BITS word, debounces it and flags changes (sticky, acked).
// BOARD_SCANNER_CHANGE_MASK_EN builds the per-bit change mask; otherwise change_mask is 0.
module board_scanner
  import board_scanner_pkg::*;
#(
  parameter int NUM_BITS = 32,
  parameter int CLK_DIV  = 50,
  parameter int DEBOUNCE = 4
) (
  input  logic            clock,
  input  logic            reset,
  board_scanner_if.slave  bus
);

  localparam int            IW         = cnt_w(NUM_BITS);
  localparam int            SW         = cnt_w(DEBOUNCE);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE - 1);

  scan_state_t r_state, w_state_nxt;
  logic w_restart, w_tc, w_sample, w_idx_load, w_idx_dec, w_commit;

  logic                    r_in_s1, r_in_s2;
  logic [IW-1:0]           r_idx;
  logic [NUM_BITS-1:0]     r_raw, r_prev_raw, r_sensor_data;
  logic [SW-1:0]           r_stable, w_stable_nxt;
  logic                    r_sr_clk, r_parallel_mode, r_data_valid, r_changed;
  logic [SCAN_COUNT_W-1:0] r_scan_count;
  logic                    w_do_commit, w_new_flip;

  scanner_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clock     (clock),
    .reset     (reset),
    .i_restart (w_restart),
    .o_tc      (w_tc)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    w_sample    = 1'b0;
    w_idx_load  = 1'b0;
    w_idx_dec   = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        w_restart = 1'b1;
        if (bus.scan_en) w_state_nxt = LOAD;
      end
      LOAD: if (w_tc) begin
        w_restart   = 1'b1;
        w_idx_load  = 1'b1;
        w_state_nxt = SHIFT_LO;
      end
      SHIFT_LO: if (w_tc) begin
        w_restart   = 1'b1;
        w_sample    = 1'b1;
        w_state_nxt = SHIFT_HI;
      end
      SHIFT_HI: if (w_tc) begin
        w_restart = 1'b1;
        if (r_idx == '0) begin
          w_state_nxt = COMMIT;
        end else begin
          w_idx_dec   = 1'b1;
          w_state_nxt = SHIFT_LO;
        end
      end
      COMMIT: begin
        w_restart   = 1'b1;
        w_commit    = 1'b1;
        w_state_nxt = bus.scan_en ? LOAD : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_stable_nxt = (r_raw != r_prev_raw) ? '0 :
                        (r_stable == STABLE_MAX) ? r_stable : r_stable + SW'(1);
  assign w_do_commit  = w_commit && (w_stable_nxt == STABLE_MAX);
  assign w_new_flip   = w_do_commit && (r_raw != r_sensor_data);

  // Pin outputs are registered from the next state so they align with the state itself.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_in_s1         <= 1'b0;
      r_in_s2         <= 1'b0;
      r_idx           <= '0;
      r_raw           <= '0;
      r_prev_raw      <= '0;
      r_stable        <= '0;
      r_sensor_data   <= '0;
      r_sr_clk        <= 1'b0;
      r_parallel_mode <= 1'b1;
      r_data_valid    <= 1'b0;
      r_changed       <= 1'b0;
      r_scan_count    <= '0;
    end else begin
      r_in_s1         <= bus.in_val;
      r_in_s2         <= r_in_s1;
      r_sr_clk        <= (w_state_nxt == SHIFT_HI);
      r_parallel_mode <= (w_state_nxt != LOAD);
      if (w_idx_load)    r_idx <= IW'(NUM_BITS - 1);
      else if (w_idx_dec) r_idx <= r_idx - IW'(1);
      if (w_sample) r_raw[r_idx] <= r_in_s2;
      if (w_commit) begin
        r_scan_count <= r_scan_count + SCAN_COUNT_W'(1);
        r_stable     <= w_stable_nxt;
        r_prev_raw   <= r_raw;
      end
      if (w_do_commit) begin
        r_data_valid  <= 1'b1;
        r_sensor_data <= r_raw;
      end
      // A new flip in the ack cycle wins over the clear.
      if (w_new_flip)          r_changed <= 1'b1;
      else if (bus.change_ack) r_changed <= 1'b0;
    end
  end

`ifdef BOARD_SCANNER_CHANGE_MASK_EN
  logic [NUM_BITS-1:0] r_change_mask;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_change_mask <= '0;
    end else begin
      r_change_mask <= (bus.change_ack ? '0 : r_change_mask) |
                       (w_new_flip ? (r_raw ^ r_sensor_data) : '0);
    end
  end

  assign bus.change_mask = r_change_mask;
`else
  assign bus.change_mask = '0;
`endif

  assign bus.sr_clk        = r_sr_clk;
  assign bus.parallel_mode = r_parallel_mode;
  assign bus.sensor_data   = r_sensor_data;
  assign bus.data_valid    = r_data_valid;
  assign bus.changed       = r_changed;
  assign bus.scan_count    = r_scan_count;

endmodule

// File: tb/tb_board_scanner.sv
// Drives a modelled PISO chain into board_scanner and checks every completed scan
// against a history-based debounce/change model.
module tb_board_scanner;

  localparam int NB    = 8;
  localparam int DIV   = 3;
  localparam int DEB   = 3;
  localparam int NW    = 64;
  localparam int NMAIN = 40;

  logic clock = 1'b0;
  logic reset;
  board_scanner_if #(.NUM_BITS(NB)) bif ();

  board_scanner #(.NUM_BITS(NB), .CLK_DIV(DIV), .DEBOUNCE(DEB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [NB-1:0] words [NW];
  bit            ack_at [NMAIN];
  int            widx = 0;
  logic [NB-1:0] r_sreg = '0;
  logic [NB-1:0] loaded_q [$];
  int            rises = 0;
  int            sr_edges = 0;

  // Reference state: scan history (seeded with the reset value of the previous word).
  logic [NB-1:0] hist [$];
  logic [NB-1:0] exp_sd, exp_mask;
  logic          exp_valid, exp_changed;
  logic [15:0]   exp_cnt;

  assign bif.in_val = r_sreg[NB-1];

  // Chain model: parallel load while parallel_mode is low, shift on sr_clk rising.
  always @(negedge bif.parallel_mode or posedge bif.sr_clk) begin
    if (!bif.parallel_mode) begin
      r_sreg = words[widx];
      loaded_q.push_back(words[widx]);
      widx  = (widx + 1) % NW;
      rises = 0;
    end else begin
      r_sreg = r_sreg << 1;
      rises++;
    end
  end

  always @(posedge bif.sr_clk or negedge bif.sr_clk) sr_edges++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    hist.push_back('0);
    exp_sd = '0; exp_mask = '0; exp_valid = 1'b0; exp_changed = 1'b0; exp_cnt = '0;
  endtask

  task automatic model_scan(input bit ack);
    logic [NB-1:0] w;
    int run;
    if (loaded_q.size() == 0) begin
      chk("chain_word_available", 0, 1);
      w = '0;
    end else begin
      w = loaded_q.pop_front();
    end
    exp_cnt = exp_cnt + 16'd1;
    hist.push_back(w);
    run = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != w) break;
      run++;
    end
    if (ack) begin
      exp_changed = 1'b0;
      exp_mask    = '0;
    end
    if (run >= DEB) begin
      exp_valid = 1'b1;
      if (w != exp_sd) begin
        exp_mask    = exp_mask | (w ^ exp_sd);
        exp_changed = 1'b1;
        exp_sd      = w;
      end
    end
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, "_sensor_data"}, bif.sensor_data, exp_sd);
    chk({ph, "_data_valid"},  bif.data_valid,  exp_valid);
    chk({ph, "_changed"},     bif.changed,     exp_changed);
`ifdef BOARD_SCANNER_CHANGE_MASK_EN
    chk({ph, "_change_mask"}, bif.change_mask, exp_mask);
`else
    chk({ph, "_change_mask"}, bif.change_mask, 0);
`endif
    chk({ph, "_scan_count"},  bif.scan_count,  exp_cnt);
  endtask

  task automatic check_reset_values(input string ph);
    chk({ph, "_sr_clk"},        bif.sr_clk,        0);
    chk({ph, "_parallel_mode"}, bif.parallel_mode, 1);
    chk({ph, "_sensor_data"},   bif.sensor_data,   0);
    chk({ph, "_data_valid"},    bif.data_valid,    0);
    chk({ph, "_changed"},       bif.changed,       0);
    chk({ph, "_change_mask"},   bif.change_mask,   0);
    chk({ph, "_scan_count"},    bif.scan_count,    0);
  endtask

  // Waits for one scan to complete, optionally acking in its commit cycle,
  // acking at random, or dropping scan_en during the high phase of bit 4.
  task automatic run_scan(input bit ack_commit, input bit rnd_ack, input bit drop);
    bit done = 1'b0;
    bit ack;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clock);
      ack = 1'b0;
      if (ack_commit && rises == NB && !bif.sr_clk && bif.parallel_mode) ack = 1'b1;
      else if (rnd_ack && $urandom_range(0, 39) == 0) ack = 1'b1;
      if (drop && rises == 4 && bif.sr_clk) bif.scan_en = 1'b0;
      bif.change_ack = ack;
      @(posedge clock);
      #1;
      if (bif.scan_count !== exp_cnt) begin
        done = 1'b1;
        model_scan(ack);
        check_outputs("scan");
      end else if (ack) begin
        exp_changed = 1'b0;
        exp_mask    = '0;
        chk("ack_clears_changed", bif.changed, 0);
      end
    end
    @(negedge clock);
    bif.change_ack = 1'b0;
    if (!done) chk("scan_completed_in_budget", 0, 1);
  endtask

  initial begin
    reset          = 1'b0;
    bif.scan_en    = 1'b0;
    bif.change_ack = 1'b0;

    words[0] = 8'hA5; words[1] = 8'hA5; words[2]  = 8'hA5;
    words[3] = 8'h0F; words[4] = 8'hF0; words[5]  = 8'h0F; words[6] = 8'hF0;
    words[7] = 8'h3C; words[8] = 8'h3C; words[9]  = 8'h3C;
    words[10] = 8'h38; words[11] = 8'h38; words[12] = 8'h38;
    for (int i = 13; i < NW; i++) begin
      if (i > 13 && $urandom_range(0, 2) != 0) words[i] = words[i-1];
      else                                     words[i] = 8'($urandom_range(0, 255));
    end
    for (int i = 0; i < NMAIN; i++) ack_at[i] = 1'b0;
    ack_at[12] = 1'b1;

    repeat (5) @(posedge clock);
    #1;
    check_reset_values("reset");
    model_reset();

    @(negedge clock);
    reset = 1'b1;
    loaded_q.delete();
    widx     = 0;
    sr_edges = 0;
    repeat (10000) @(posedge clock);
    #1;
    chk("idle_sr_clk_edges",     sr_edges,          0);
    chk("idle_parallel_mode",    bif.parallel_mode, 1);
    chk("idle_scan_count",       bif.scan_count,    0);

    @(negedge clock);
    bif.scan_en = 1'b1;
    for (int s = 0; s < NMAIN; s++) run_scan(ack_at[s], s >= 13, 1'b0);

    run_scan(1'b0, 1'b0, 1'b1);
    sr_edges = 0;
    repeat (60) @(posedge clock);
    #1;
    chk("stopped_sr_clk_edges",  sr_edges,          0);
    chk("stopped_parallel_mode", bif.parallel_mode, 1);
    chk("stopped_scan_count",    bif.scan_count,    exp_cnt);

    @(negedge clock);
    force dut.r_scan_count = 16'hFFFF;
    @(negedge clock);
    release dut.r_scan_count;
    exp_cnt = 16'hFFFF;
    @(posedge clock);
    #1;
    chk("preload_scan_count", bif.scan_count, 16'hFFFF);
    @(negedge clock);
    bif.scan_en = 1'b1;
    run_scan(1'b0, 1'b1, 1'b0);

    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (rises == 3) break;
    end
    chk("reached_mid_scan", rises, 3);
    reset = 1'b0;
    #1;
    check_reset_values("midscan_reset");
    model_reset();
    loaded_q.delete();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int s = 0; s < 4; s++) run_scan(1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
